// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing parameters (10 ms at 100 MHz).
package debounce_pkg;

    localparam int DEF_STABLE_COUNT = 1000000;
    localparam int DEF_CNT_WIDTH    = 20;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the raw asynchronous input into the clk
// domain; both flops clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // NOTE: sequential state uses non-blocking assignments so s1 and q both
    // sample their pre-edge values and form a true two-stage pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer: synchronized input must disagree with q for STABLE_COUNT
// consecutive cycles before q flips; rise/fall are registered one-cycle pulses.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    state_e               state;
    state_e               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 s2;
    logic                 q_next;
    logic                 rise_next;
    logic                 fall_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s2)
    );

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        q_next     = q;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            IDLE_LOW: begin
                cnt_next = '0;
                if (s2) state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    q_next     = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                cnt_next = '0;
                if (!s2) state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    q_next     = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                q_next     = 1'b0;
            end
        endcase
    end

    // q, rise and fall come straight from flops: no combinational path from din.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            q     <= q_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule
